lsu_arbiter: RTL and testbench

Two-requester arbiter and burst sequencer that shares the single-port word-addressed LSU memory between the core datapath (port 0) and a DMA/debug engine (port 1). It sits between the core's memory-stage signals and the LSU's `addr_i`/`dataW_i`/`MemRW_i`/`dataR_o` pins. It grants at most one access per cycle, round-robin between ports. DMA bursts auto-increment the address, and a starvation limit guarantees the core a slot during long bursts.

---
 rtl/lsu_arb_pkg.sv | 17 +
 rtl/lsu_arb_burst_ctr.sv | 59 +++++
 rtl/lsu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_lsu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_arb_pkg.sv
// Shared types and default sizing for the LSU arbiter and its burst counter.
package lsu_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DMA  = 1'b1
    } port_e;

    localparam int DEF_BURST_W      = 4;
    localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/lsu_arb_burst_ctr.sv
// Holds the latched burst descriptor and the beat index; produces the address
// of the current in-burst beat and flags when that beat is the final one.
module lsu_arb_burst_ctr
    import lsu_arb_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               advance_i,
    input  logic [31:0]        base_i,
    input  logic [BURST_W-1:0] len_i,
    input  logic               we_i,
    output logic [31:0]        addr_o,
    output logic               we_o,
    output logic               last_o
);

    logic [31:0]        base_q, base_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] beat_q, beat_d;
    logic               we_q, we_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        beat_d = beat_q;
        we_d   = we_q;
        // Beat 0 goes out on the start cycle, so the first in-burst beat is 1.
        if (start_i) begin
            base_d = base_i;
            len_d  = len_i;
            we_d   = we_i;
            beat_d = BURST_W'(1);
        end else if (advance_i) begin
            beat_d = beat_q + BURST_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
            we_q   <= 1'b0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            beat_q <= beat_d;
            we_q   <= we_d;
        end
    end

    assign addr_o = base_q + 32'(beat_q);
    assign we_o   = we_q;
    assign last_o = (beat_q == len_q);

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter between the core and a DMA burst engine in front of the
// single-port LSU, with a starvation slot that lets the core into long bursts.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int BURST_W      = DEF_BURST_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wdata_i,
    output logic               core_gnt_o,
    output logic               core_rvalid_o,
    output logic [31:0]        core_rdata_o,
    input  logic               dma_req_i,
    input  logic               dma_we_i,
    input  logic [31:0]        dma_addr_i,
    input  logic [BURST_W-1:0] dma_len_i,
    input  logic [31:0]        dma_wdata_i,
    output logic               dma_gnt_o,
    output logic               dma_rvalid_o,
    output logic [31:0]        dma_rdata_o,
    output logic               dma_done_o,
    output logic [31:0]        lsu_addr_o,
    output logic [31:0]        lsu_wdata_o,
    output logic               lsu_we_o,
    input  logic [31:0]        lsu_rdata_i
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e  state_q, state_d;
    port_e       last_gnt_q, last_gnt_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic        done_q, done_d;
    logic        core_rvalid_q, core_rvalid_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic        dma_rvalid_q, dma_rvalid_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    logic        core_gnt, dma_gnt;
    logic        burst_start, burst_adv, dma_last;
    logic [31:0] burst_addr;
    logic        burst_we, burst_last;

    lsu_arb_burst_ctr #(
        .BURST_W (BURST_W)
    ) u_burst_ctr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (burst_start),
        .advance_i (burst_adv),
        .base_i    (dma_addr_i),
        .len_i     (dma_len_i),
        .we_i      (dma_we_i),
        .addr_o    (burst_addr),
        .we_o      (burst_we),
        .last_o    (burst_last)
    );

    always_comb begin
        core_gnt    = 1'b0;
        dma_gnt     = 1'b0;
        burst_start = 1'b0;
        burst_adv   = 1'b0;
        dma_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req_i && (!dma_req_i || last_gnt_q == PORT_DMA)) begin
                    core_gnt = 1'b1;
                end else if (dma_req_i) begin
                    dma_gnt     = 1'b1;
                    burst_start = 1'b1;
                    dma_last    = (dma_len_i == '0);
                end
            end
            BURST: begin
                // dma_req_i is ignored here; only a starved core can steal the slot.
                if (core_req_i && starve_cnt_q == SC_W'(STARVE_LIMIT)) begin
                    core_gnt = 1'b1;
                end else begin
                    dma_gnt   = 1'b1;
                    burst_adv = 1'b1;
                    dma_last  = burst_last;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        lsu_addr_o  = '0;
        lsu_wdata_o = '0;
        lsu_we_o    = 1'b0;
        if (core_gnt) begin
            lsu_addr_o  = core_addr_i;
            lsu_wdata_o = core_wdata_i;
            lsu_we_o    = core_we_i;
        end else if (burst_start) begin
            lsu_addr_o  = dma_addr_i;
            lsu_wdata_o = dma_wdata_i;
            lsu_we_o    = dma_we_i;
        end else if (burst_adv) begin
            lsu_addr_o  = burst_addr;
            lsu_wdata_o = dma_wdata_i;
            lsu_we_o    = burst_we;
        end
    end

    always_comb begin
        state_d = state_q;
        if (burst_start && !dma_last) begin
            state_d = BURST;
        end else if (burst_adv && dma_last) begin
            state_d = IDLE;
        end

        last_gnt_d = last_gnt_q;
        if (core_gnt) begin
            last_gnt_d = PORT_CORE;
        end else if (dma_last) begin
            last_gnt_d = PORT_DMA;
        end

        starve_cnt_d = starve_cnt_q;
        if (!core_req_i || core_gnt) begin
            starve_cnt_d = '0;
        end else if (dma_gnt && starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end

        done_d        = dma_last;
        core_rvalid_d = core_gnt && !core_we_i;
        core_rdata_d  = core_rvalid_d ? lsu_rdata_i : core_rdata_q;
        dma_rvalid_d  = dma_gnt && !lsu_we_o;
        dma_rdata_d   = dma_rvalid_d ? lsu_rdata_i : dma_rdata_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_gnt_q    <= PORT_DMA;
            starve_cnt_q  <= '0;
            done_q        <= 1'b0;
            core_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            dma_rvalid_q  <= 1'b0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            starve_cnt_q  <= starve_cnt_d;
            done_q        <= done_d;
            core_rvalid_q <= core_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            dma_rvalid_q  <= dma_rvalid_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    assign core_gnt_o    = core_gnt;
    assign dma_gnt_o     = dma_gnt;
    assign core_rvalid_o = core_rvalid_q;
    assign core_rdata_o  = core_rdata_q;
    assign dma_rvalid_o  = dma_rvalid_q;
    assign dma_rdata_o   = dma_rdata_q;
    assign dma_done_o    = done_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the arbiter.
module tb_lsu_arbiter;

    localparam int BW = 4;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          core_req_i, core_we_i;
    logic [31:0]   core_addr_i, core_wdata_i;
    logic          core_gnt_o, core_rvalid_o;
    logic [31:0]   core_rdata_o;
    logic          dma_req_i, dma_we_i;
    logic [31:0]   dma_addr_i, dma_wdata_i;
    logic [BW-1:0] dma_len_i;
    logic          dma_gnt_o, dma_rvalid_o, dma_done_o;
    logic [31:0]   dma_rdata_o;
    logic [31:0]   lsu_addr_o, lsu_wdata_o, lsu_rdata_i;
    logic          lsu_we_o;

    lsu_arbiter #(.BURST_W(BW), .STARVE_LIMIT(SL)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_len_i(dma_len_i), .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o),
        .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o), .dma_done_o(dma_done_o),
        .lsu_addr_o(lsu_addr_o), .lsu_wdata_o(lsu_wdata_o), .lsu_we_o(lsu_we_o),
        .lsu_rdata_i(lsu_rdata_i)
    );

    initial forever #5 clk = ~clk;

    // LSU stand-in: 256 words, aliased on the low address byte.
    logic [31:0] mem [256];
    assign lsu_rdata_i = mem[lsu_addr_o[7:0]];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: what is owed to whom, not how the RTL stores it.
    bit          m_last_dma;
    int          m_left;
    bit [31:0]   m_addr;
    bit          m_we;
    int          m_wait;
    bit          m_core_rv, m_dma_rv, m_done;
    bit [31:0]   m_core_rd, m_dma_rd;
    bit [31:0]   ref_mem [256];
    bit          g_core, g_dma, g_start;
    logic [31:0] o_core_gnt, o_dma_gnt, o_addr, o_we, o_core_rv, o_core_rd, o_done;

    task automatic model_reset();
        m_last_dma = 1'b1;
        m_left = 0;
        m_addr = '0;
        m_we = 1'b0;
        m_wait = 0;
        m_core_rv = 1'b0;
        m_dma_rv = 1'b0;
        m_done = 1'b0;
        m_core_rd = '0;
        m_dma_rd = '0;
    endtask

    task automatic step();
        bit [31:0] e_addr, e_wd, e_rd;
        bit e_we;
        @(negedge clk);
        g_core = 1'b0; g_dma = 1'b0; g_start = 1'b0;
        e_addr = '0; e_wd = '0; e_we = 1'b0;
        if (m_left > 0) begin
            if (core_req_i && m_wait >= SL) g_core = 1'b1;
            else g_dma = 1'b1;
        end else if (core_req_i && (!dma_req_i || m_last_dma)) begin
            g_core = 1'b1;
        end else if (dma_req_i) begin
            g_dma = 1'b1; g_start = 1'b1;
            m_addr = dma_addr_i; m_we = dma_we_i; m_left = int'(dma_len_i) + 1;
        end
        if (g_core) begin
            e_addr = core_addr_i; e_we = core_we_i; e_wd = core_wdata_i;
        end else if (g_dma) begin
            e_addr = m_addr; e_we = m_we; e_wd = dma_wdata_i;
        end

        o_core_gnt = 32'(core_gnt_o); o_dma_gnt = 32'(dma_gnt_o);
        o_addr = lsu_addr_o; o_we = 32'(lsu_we_o);
        o_core_rv = 32'(core_rvalid_o); o_core_rd = core_rdata_o; o_done = 32'(dma_done_o);

        check_eq("core_gnt", 32'(core_gnt_o), 32'(g_core));
        check_eq("dma_gnt", 32'(dma_gnt_o), 32'(g_dma));
        check_eq("lsu_addr", lsu_addr_o, e_addr);
        check_eq("lsu_we", 32'(lsu_we_o), 32'(e_we));
        check_eq("lsu_wdata", lsu_wdata_o, e_we ? e_wd : (g_core || g_dma ? lsu_wdata_o : 32'h0));
        check_eq("core_rvalid", 32'(core_rvalid_o), 32'(m_core_rv));
        check_eq("core_rdata", core_rdata_o, m_core_rd);
        check_eq("dma_rvalid", 32'(dma_rvalid_o), 32'(m_dma_rv));
        check_eq("dma_rdata", dma_rdata_o, m_dma_rd);
        check_eq("dma_done", 32'(dma_done_o), 32'(m_done));

        if (lsu_we_o) mem[lsu_addr_o[7:0]] = lsu_wdata_o;

        e_rd = ref_mem[e_addr[7:0]];
        if (e_we && (g_core || g_dma)) ref_mem[e_addr[7:0]] = e_wd;
        m_core_rv = g_core && !e_we;
        if (m_core_rv) m_core_rd = e_rd;
        m_dma_rv = g_dma && !e_we;
        if (m_dma_rv) m_dma_rd = e_rd;
        m_done = 1'b0;
        if (!core_req_i || g_core) m_wait = 0;
        else if (g_dma) m_wait++;
        if (g_core) m_last_dma = 1'b0;
        if (g_dma) begin
            m_addr++;
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_last_dma = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dma_start(input bit we, input logic [31:0] addr, input logic [BW-1:0] len);
        dma_req_i = 1'b1; dma_we_i = we; dma_addr_i = addr; dma_len_i = len;
    endtask

    initial begin
        int beats;
        bit seen;
        rst_i = 1'b1;
        core_req_i = 1'b0; core_we_i = 1'b0; core_addr_i = '0; core_wdata_i = '0;
        dma_req_i = 1'b0; dma_we_i = 1'b0; dma_addr_i = '0; dma_len_i = '0; dma_wdata_i = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        model_reset();

        #12;
        check_eq("rst_core_rvalid", 32'(core_rvalid_o), 32'h0);
        check_eq("rst_core_rdata", core_rdata_o, 32'h0);
        check_eq("rst_dma_done", 32'(dma_done_o), 32'h0);
        check_eq("rst_lsu_addr", lsu_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Round-robin from reset plus core read of address 5.
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'd5;
        dma_start(1'b1, 32'h40, 4'd0); dma_wdata_i = 32'h1234;
        step();
        check_eq("rr0_core_first", o_core_gnt, 32'd1);
        check_eq("rr0_dma_waits", o_dma_gnt, 32'd0);
        check_eq("rd5_addr", o_addr, 32'd5);
        core_req_i = 1'b0;
        step();
        check_eq("rr0_dma_second", o_dma_gnt, 32'd1);
        check_eq("rd5_rvalid", o_core_rv, 32'd1);
        check_eq("rd5_rdata", o_core_rd, 32'hDEADBEEF);
        dma_req_i = 1'b0;
        step();
        check_eq("single_beat_done", o_done, 32'd1);

        // Core went last: DMA must win the next tie.
        core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h20; core_wdata_i = 32'hCAFE0001;
        step();
        check_eq("rr1_core_alone", o_core_gnt, 32'd1);
        core_we_i = 1'b0; core_addr_i = 32'h21;
        dma_start(1'b1, 32'h41, 4'd0);
        step();
        check_eq("rr1_dma_first", o_dma_gnt, 32'd1);
        check_eq("rr1_core_waits", o_core_gnt, 32'd0);
        dma_req_i = 1'b0;
        step();
        check_eq("rr1_core_next", o_core_gnt, 32'd1);
        core_req_i = 1'b0;
        step();

        // Four-beat write burst.
        dma_start(1'b1, 32'h10, 4'd3);
        for (int i = 0; i < 4; i++) begin
            dma_wdata_i = 32'(i + 1);
            step();
            check_eq("bw_addr", o_addr, 32'h10 + 32'(i));
            check_eq("bw_we", o_we, 32'd1);
            check_eq("bw_no_early_done", o_done, 32'd0);
            dma_req_i = 1'b0;
        end
        step();
        check_eq("bw_done", o_done, 32'd1);

        // Long read burst with the core asking from beat 2.
        dma_start(1'b0, 32'h80, 4'd15);
        step();
        dma_req_i = 1'b0;
        step();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h30;
        beats = 0; seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (o_core_gnt[0]) seen = 1'b1;
            else if (o_dma_gnt[0]) beats++;
        end
        check_eq("starve_slot_seen", 32'(seen), 32'd1);
        check_eq("starve_beats", 32'(beats), 32'(SL));
        check_eq("starve_dma_held", o_dma_gnt, 32'd0);
        core_req_i = 1'b0;
        step();
        check_eq("starve_resume_addr", o_addr, 32'h86);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (o_done[0]) seen = 1'b1;
        end
        check_eq("starve_burst_done", 32'(seen), 32'd1);

        // Address wrap-around.
        dma_start(1'b1, 32'hFFFFFFFF, 4'd1);
        dma_wdata_i = 32'hA5A5A5A5;
        step();
        check_eq("wrap_addr0", o_addr, 32'hFFFFFFFF);
        dma_req_i = 1'b0;
        step();
        check_eq("wrap_addr1", o_addr, 32'h00000000);
        step();
        check_eq("wrap_done", o_done, 32'd1);

        // Reset in the middle of a read burst.
        dma_start(1'b0, 32'h50, 4'd7);
        step();
        dma_req_i = 1'b0;
        step();
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_dma_gnt", 32'(dma_gnt_o), 32'h0);
        check_eq("mid_rst_lsu_addr", lsu_addr_o, 32'h0);
        check_eq("mid_rst_lsu_we", 32'(lsu_we_o), 32'h0);
        check_eq("mid_rst_dma_rvalid", 32'(dma_rvalid_o), 32'h0);
        check_eq("mid_rst_dma_rdata", dma_rdata_o, 32'h0);
        check_eq("mid_rst_core_rdata", core_rdata_o, 32'h0);
        check_eq("mid_rst_done", 32'(dma_done_o), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) step();
        core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'd5;
        step();
        check_eq("post_rst_core_gnt", o_core_gnt, 32'd1);
        core_req_i = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (g_core) core_req_i = 1'b0;
            if (g_dma) dma_wdata_i = $urandom;
            if (g_start) dma_req_i = 1'b0;
            if (!core_req_i && $urandom_range(0, 2) == 0) begin
                core_req_i = 1'b1;
                core_we_i = 1'($urandom);
                core_addr_i = $urandom;
                core_wdata_i = $urandom;
            end
            if (!dma_req_i && $urandom_range(0, 9) == 0) begin
                dma_req_i = 1'b1;
                dma_we_i = 1'($urandom);
                dma_addr_i = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
                dma_len_i = BW'($urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
